// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_PAD  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [31:0] PAD_WORD        = 32'h8000_0000;
  localparam int          BLOCK_W         = 512;
  localparam int          WORDS_PER_BLOCK = 16;
  localparam logic [3:0]  LEN_HI_IDX      = 4'd14;
  localparam logic [3:0]  LEN_LO_IDX      = 4'd15;

  // Byte count of a final word in bits; code 0 means a full word.
  function automatic logic [5:0] bytes_to_bits(input logic [1:0] nb);
    return {(nb == 2'd0), nb, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Word-in / block-out handshake bundle between message source, padder and round engine.
interface sha256_msg_padder_if;
  import sha256_pkg::*;

  logic [31:0]        i_data;
  logic               i_valid;
  logic               i_last;
  logic [1:0]         i_last_bytes;
  logic               o_ready;
  logic [BLOCK_W-1:0] o_block;
  logic               o_block_valid;
  logic               i_block_ready;
  logic               o_block_first;
  logic               o_block_last;

  modport slave (
    input  i_data, i_valid, i_last, i_last_bytes, i_block_ready,
    output o_ready, o_block, o_block_valid, o_block_first, o_block_last
  );

  modport master (
    output i_data, i_valid, i_last, i_last_bytes, i_block_ready,
    input  o_ready, o_block, o_block_valid, o_block_first, o_block_last
  );
endinterface

// File: rtl/sha256_pad_word.sv
// Final-word shaping: zero bytes past the valid count and drop the 0x80 marker after them.
import sha256_pkg::*;

module sha256_pad_word (
  input  logic [31:0] data,
  input  logic [1:0]  last_bytes,
  output logic [31:0] word,
  output logic [5:0]  nbits,
  output logic        full
);

  always_comb begin
    word = data;
    case (last_bytes)
      2'd1:    word = {data[31:24], 8'h80, 16'h0000};
      2'd2:    word = {data[31:16], 8'h80, 8'h00};
      2'd3:    word = {data[31:8], 8'h80};
      default: word = data;
    endcase
  end

  assign full  = (last_bytes == 2'd0);
  assign nbits = bytes_to_bits(last_bytes);

endmodule

// File: rtl/sha256_msg_padder.sv
// Packs 32-bit message words into 512-bit SHA-256 blocks and appends marker and length padding.
import sha256_pkg::*;

module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  sha256_msg_padder_if.slave  bus
);

  state_t                              state;
  logic [3:0]                          cnt;
  logic [LEN_W-1:0]                    len;
  logic [0:WORDS_PER_BLOCK-1][31:0]    blk;
  logic                                mark_pend;  // full last word: 0x80000000 still owed
  logic                                len_fit;    // length words belong in the current block
  logic                                pad_act;    // message ended, padding not yet emitted
  logic                                first_flg;
  logic                                blk_vld, blk_first, blk_last;
  logic [31:0]                         last_word;
  logic [5:0]                          last_bits;
  logic                                last_full;
  logic [63:0]                         len64;
  logic [31:0]                         pad_val;

  sha256_pad_word u_pad (
    .data       (bus.i_data),
    .last_bytes (bus.i_last_bytes),
    .word       (last_word),
    .nbits      (last_bits),
    .full       (last_full)
  );

  assign len64             = 64'(len);
  assign bus.o_ready       = i_rst_n && (state == S_DATA);
  assign bus.o_block       = blk;
  assign bus.o_block_valid = blk_vld;
  assign bus.o_block_first = blk_first;
  assign bus.o_block_last  = blk_last;

  always_comb begin
    pad_val = '0;
    if (mark_pend)                       pad_val = PAD_WORD;
    else if (len_fit && cnt == LEN_HI_IDX) pad_val = len64[63:32];
    else if (len_fit && cnt == LEN_LO_IDX) pad_val = len64[31:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_DATA;
      cnt       <= '0;
      len       <= '0;
      blk       <= '0;
      mark_pend <= 1'b0;
      len_fit   <= 1'b0;
      pad_act   <= 1'b0;
      first_flg <= 1'b1;
      blk_vld   <= 1'b0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
    end else begin
      case (state)
        S_DATA: if (bus.i_valid) begin
          cnt <= cnt + 4'd1;
          if (!bus.i_last) begin
            blk[cnt] <= bus.i_data;
            len      <= len + LEN_W'(32);
            if (cnt == 4'd15) begin
              state     <= S_OUT;
              blk_vld   <= 1'b1;
              blk_first <= first_flg;
              first_flg <= 1'b0;
              blk_last  <= 1'b0;
            end
          end else begin
            blk[cnt]  <= last_word;
            len       <= len + LEN_W'(last_bits);
            pad_act   <= 1'b1;
            mark_pend <= last_full;
            len_fit   <= !last_full && (cnt <= 4'd13);
            if (cnt == 4'd15) begin
              state     <= S_OUT;
              blk_vld   <= 1'b1;
              blk_first <= first_flg;
              first_flg <= 1'b0;
              blk_last  <= 1'b0;
            end else begin
              state <= S_PAD;
            end
          end
        end

        S_PAD: begin
          blk[cnt] <= pad_val;
          cnt      <= cnt + 4'd1;
          // The marker decides whether two length words still fit behind it.
          if (mark_pend) begin
            mark_pend <= 1'b0;
            len_fit   <= (cnt <= 4'd13);
          end
          if (cnt == 4'd15) begin
            state     <= S_OUT;
            blk_vld   <= 1'b1;
            blk_first <= first_flg;
            first_flg <= 1'b0;
            blk_last  <= !mark_pend && len_fit;
          end
        end

        S_OUT: if (bus.i_block_ready) begin
          blk_vld   <= 1'b0;
          blk_first <= 1'b0;
          blk_last  <= 1'b0;
          blk       <= '0;
          cnt       <= '0;
          if (blk_last) begin
            pad_act   <= 1'b0;
            len       <= '0;
            first_flg <= 1'b1;
            state     <= S_DATA;
          end else if (pad_act) begin
            len_fit <= 1'b1;
            state   <= S_PAD;
          end else begin
            state <= S_DATA;
          end
        end

        default: state <= S_DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: constant vectors, byte-level padding model, random gaps and backpressure.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;
  typedef struct {
    int          nbytes;
    int          nblk;
    logic [31:0] w0;
    logic [31:0] w15;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  sha256_msg_padder_if bus();
  sha256_msg_padder #(.LEN_W(64)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  always #5 i_clk = ~i_clk;

  int           checks = 0;
  int           errors = 0;
  int           rdy_pct = 100;
  int           blk_cnt = 0;
  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [511:0] last_blk = '0;
  vec_t         vecs[10];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bq_t mk_msg(input int n, input bit rnd);
    bq_t m;
    for (int i = 0; i < n; i++) m.push_back(rnd ? 8'($urandom) : 8'(8'h61 + i));
    return m;
  endfunction

  // Standard SHA-256 padding on a byte array, cut into 64-byte blocks.
  task automatic model_push(input bq_t m);
    bq_t        p;
    bit [63:0]  bits;
    int         nb;
    exp_t       e;
    p    = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int j = 0; j < 64; j++) e.blk[511-8*j -: 8] = p[64*b+j];
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] lb, input bit gaps);
    int guard = 0;
    while (gaps && $urandom_range(0, 2) == 0) begin
      @(negedge i_clk);
      bus.i_valid      = 1'b0;
      bus.i_data       = $urandom;
      bus.i_last       = 1'($urandom);
      bus.i_last_bytes = 2'($urandom);
    end
    @(negedge i_clk);
    bus.i_valid      = 1'b1;
    bus.i_data       = d;
    bus.i_last       = last;
    bus.i_last_bytes = lb;
    while (!bus.o_ready && guard < 3000) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 3000) check("ready_timeout", 512'(guard), 512'(0));
    @(posedge i_clk);
  endtask

  task automatic send_msg(input bq_t m, input bit gaps);
    int          n;
    int          nw;
    logic [31:0] wd;
    n  = m.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 4; j++) wd[31-8*j -: 8] = (4 * w + j < n) ? m[4*w+j] : 8'($urandom);
      send_word(wd, (w == nw - 1), 2'(n % 4), gaps);
    end
    @(negedge i_clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge i_clk);
      g++;
    end
    check("drain", 512'(exp_q.size()), 512'(0));
    exp_q.delete();
    repeat (3) @(negedge i_clk);
  endtask

  // Block sink: random ready, compare each handshaken block with the model.
  initial forever begin
    @(negedge i_clk);
    bus.i_block_ready = ($urandom_range(0, 99) < rdy_pct);
    if (i_rst_n && bus.o_block_valid && bus.i_block_ready) begin
      blk_cnt++;
      last_blk = bus.o_block;
      check("blk_expected", 512'(exp_q.size() != 0), 512'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("blk_data", bus.o_block, mon_e.blk);
        check("blk_first", 512'(bus.o_block_first), 512'(mon_e.first));
        check("blk_last", 512'(bus.o_block_last), 512'(mon_e.last));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] hold;
    int           g;
    bq_t          m1;
    bq_t          m2;

    vecs[0] = '{1,  1, 32'h61800000, 32'h00000008};
    vecs[1] = '{3,  1, 32'h61626380, 32'h00000018};
    vecs[2] = '{4,  1, 32'h61626364, 32'h00000020};
    vecs[3] = '{52, 1, 32'h61626364, 32'h000001A0};
    vecs[4] = '{55, 1, 32'h61626364, 32'h000001B8};
    vecs[5] = '{56, 2, 32'h00000000, 32'h000001C0};
    vecs[6] = '{57, 2, 32'h00000000, 32'h000001C8};
    vecs[7] = '{60, 2, 32'h00000000, 32'h000001E0};
    vecs[8] = '{63, 2, 32'h00000000, 32'h000001F8};
    vecs[9] = '{64, 2, 32'h80000000, 32'h00000200};

    bus.i_valid      = 1'b0;
    bus.i_data       = '0;
    bus.i_last       = 1'b0;
    bus.i_last_bytes = '0;

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_ready", 512'(bus.o_ready), 512'(0));
    check("rst_valid", 512'(bus.o_block_valid), 512'(0));
    check("rst_first", 512'(bus.o_block_first), 512'(0));
    check("rst_last", 512'(bus.o_block_last), 512'(0));
    check("rst_block", bus.o_block, 512'(0));
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("ready_after_rst", 512'(bus.o_ready), 512'(1));

    // Constant vectors around the 55/56/64-byte boundaries
    rdy_pct = 100;
    for (int v = 0; v < 10; v++) begin
      m1 = mk_msg(vecs[v].nbytes, 1'b0);
      blk_cnt = 0;
      model_push(m1);
      send_msg(m1, 1'b0);
      wait_drain();
      check($sformatf("vec%0d_nblk", v), 512'(blk_cnt), 512'(vecs[v].nblk));
      check($sformatf("vec%0d_w0", v), 512'(last_blk[511 -: 32]), 512'(vecs[v].w0));
      check($sformatf("vec%0d_w15", v), 512'(last_blk[31:0]), 512'(vecs[v].w15));
    end

    // Back-to-back messages: first flag and length restart per message
    blk_cnt = 0;
    m1 = mk_msg(3, 1'b0);
    model_push(m1);
    model_push(m1);
    send_msg(m1, 1'b0);
    send_msg(m1, 1'b0);
    wait_drain();
    check("b2b_nblk", 512'(blk_cnt), 512'(2));
    check("b2b_w15", 512'(last_blk[31:0]), 512'(32'h18));

    // Backpressure: block held 5 cycles while the next message stalls
    rdy_pct = 0;
    m1 = mk_msg(20, 1'b1);
    m2 = mk_msg(9, 1'b1);
    model_push(m1);
    model_push(m2);
    fork
      begin
        send_msg(m1, 1'b1);
        send_msg(m2, 1'b1);
      end
      begin
        g = 0;
        while (!bus.o_block_valid && g < 200) begin
          @(negedge i_clk);
          g++;
        end
        check("bp_valid_seen", 512'(bus.o_block_valid), 512'(1));
        hold = bus.o_block;
        for (int c = 0; c < 5; c++) begin
          @(negedge i_clk);
          check("bp_block_stable", bus.o_block, hold);
          check("bp_ready_low", 512'(bus.o_ready), 512'(0));
        end
        rdy_pct = 100;
      end
    join
    wait_drain();

    // Randomized messages with valid gaps and random ready
    rdy_pct = 60;
    for (int k = 0; k < 20; k++) begin
      m1 = mk_msg($urandom_range(1, 150), 1'b1);
      model_push(m1);
      send_msg(m1, 1'b1);
    end
    rdy_pct = 100;
    wait_drain();

    // Reset at cnt=7, then "abc"
    for (int w = 0; w < 7; w++) send_word($urandom, 1'b0, 2'd0, 1'b0);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    i_rst_n     = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("mid_rst_ready", 512'(bus.o_ready), 512'(0));
    check("mid_rst_valid", 512'(bus.o_block_valid), 512'(0));
    check("mid_rst_flags", 512'({bus.o_block_first, bus.o_block_last}), 512'(0));
    check("mid_rst_block", bus.o_block, 512'(0));
    i_rst_n = 1'b1;
    blk_cnt = 0;
    m1 = mk_msg(3, 1'b0);
    model_push(m1);
    send_msg(m1, 1'b0);
    wait_drain();
    check("abc_nblk", 512'(blk_cnt), 512'(1));
    check("abc_w0", 512'(last_blk[511 -: 32]), 512'(32'h61626380));
    check("abc_w15", 512'(last_blk[31:0]), 512'(32'h18));
    repeat (20) @(negedge i_clk);
    check("no_stray_blk", 512'(blk_cnt), 512'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 Parameter: LEN_W, 64, message bit-length counter width (legal 32..64); zero-extended into the 64-bit length field.
REQ-002 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-003 i_rst_n  in  1  synchronous, active-low reset.
REQ-004 i_data  in  32  message word, big-endian; first byte in [31:24].
REQ-005 i_valid  in  1  i_data valid.
REQ-006 i_last  in  1  qualifies final word of a message.
REQ-007 i_last_bytes  in  2  valid bytes in the final word, MSB-aligned; 0 encodes 4.
REQ-008 o_ready  out  1  padder accepts i_data this cycle.
REQ-009 o_block  out  512  padded block; word k occupies bits [511-32k : 480-32k], so word 0 is W0 (oldest schedule word).
REQ-010 o_block_valid  out  1  o_block complete and stable.
REQ-011 i_block_ready  in  1  round engine accepts o_block.
REQ-012 o_block_first  out  1  block is the first of its message; engine loads initial hash values.
REQ-013 o_block_last  out  1  block is the final block of its message; it carries the length field.

Function
REQ-014 States are S_DATA, S_PAD, and S_OUT.
REQ-015 S_DATA: o_ready=1; a word transfers on i_valid&o_ready; it is written to word index cnt (0..15); cnt increments.
REQ-016 Bit length increments by 32 per non-last word and by 8*bytes for the last word, modulo 2^LEN_W.
REQ-017 Non-last word at cnt=15 completes the block -> S_OUT with o_block_last=0.
REQ-018 Partial last word: bytes beyond the valid count are zeroed, and 0x80 is placed in the first invalid byte.
REQ-019 Full last word: a 0x80000000 word is pending -> S_PAD.
REQ-020 S_PAD: o_ready=0; one word is written per cycle: the pending 0x80000000 first, then zeros.
REQ-021 In S_PAD, the length high/low words are written at cnt=14/15 only if the pad began at cnt<=13 in this block.
REQ-022 If padding cannot fit the length (pad marker landed at cnt 14 or 15, or the block filled), the rest is zero-filled and emitted with o_block_last=0; a further all-zero block carrying the length at words 14/15 follows with o_block_last=1.
REQ-023 If a partial last word leaves cnt<=14, the length is written directly; no extra block is needed.
REQ-024 S_OUT: o_ready=0, o_block_valid=1; o_block, o_block_first, and o_block_last are held stable until i_block_ready.
REQ-025 On the S_OUT handshake, cnt is cleared and the block buffer is zeroed.
REQ-026 After an S_OUT handshake: return to S_PAD if padding is unfinished; otherwise return to S_DATA.
REQ-027 After the final block handshakes, the length counter clears and the next block asserts o_block_first.
REQ-028 o_block_valid rises the cycle after the 16th word is written (word accepted or pad word generated); throughput is one word per cycle.
REQ-029 i_data, i_last, and i_last_bytes are ignored when i_valid=0 or o_ready=0.
REQ-030 Zero-length messages are out of scope; i_last always accompanies at least one byte.

Reset
REQ-031 While i_rst_n=0 at an edge: state=S_DATA, cnt=0, length=0, block buffer=0, pending flags=0, first flag=1.
REQ-032 While i_rst_n=0 at an edge: o_block_valid=0, o_block_first=0, o_block_last=0, o_block=0.
REQ-033 o_ready is forced to 0 while i_rst_n=0.
REQ-034 Reset mid-message or mid-S_OUT discards the partial message; no block is emitted afterwards for it.

Structure
REQ-035 sha256_pkg holds: the state encoding, PAD_WORD=32'h80000000, BLOCK_W=512, WORDS_PER_BLOCK=16, and the length-word indices 14 and 15.
REQ-036 One combinational sub-module, sha256_pad_word, performs byte masking and 0x80 insertion for the final word; all sequencing lives in the top module.

Verification
REQ-037 Message "abc": i_data=0x61626300, last, i_last_bytes=3 -> one block, word0=0x61626380, words1-14=0, word15=0x00000018, first=last=1.
REQ-038 55-byte message -> one block, length word15=0x000001B8; 56-byte message -> two blocks, the second all zero except word15=0x000001C0.
REQ-039 64-byte message (16 full words) -> block 1 with last=0, then block 2 with word0=0x80000000 and word15=0x00000200, last=1.
REQ-040 Backpressure: i_block_ready low for 5 cycles -> o_block stable, o_ready=0, no word lost, with random i_valid gaps.
REQ-041 Two back-to-back messages -> o_block_first set only on each message's first block; the length restarts from 0.
REQ-042 Reset asserted at cnt=7 -> all outputs 0 next cycle; a following "abc" message produces the REQ-037 block exactly.
